// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller: FSM encoding,
// default engine timeout and read-select constants.
package hilo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    localparam int TIMEOUT_DEFAULT = 40;

    localparam logic RD_LO = 1'b0;
    localparam logic RD_HI = 1'b1;

endpackage

// File: rtl/hilo_regs.sv
// HI/LO architectural registers: engine result capture has priority over
// direct mthi/mtlo writes; combinational read mux.
module hilo_regs
    import hilo_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cap_i,
    input  logic [31:0] cap_hi_i,
    input  logic [31:0] cap_lo_i,
    input  logic        wr_en_i,
    input  logic        wr_hi_i,
    input  logic        wr_lo_i,
    input  logic [31:0] wr_data_i,
    input  logic        rd_sel_i,
    output logic [31:0] rd_data_o
);

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // NOTE: next-state defaults to the current value first, so no path leaves hi_d/lo_d unassigned (no latch).
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (cap_i) begin
            hi_d = cap_hi_i;
            lo_d = cap_lo_i;
        end else if (wr_en_i) begin
            if (wr_hi_i) hi_d = wr_data_i;
            if (wr_lo_i) lo_d = wr_data_i;
        end
    end

    // NOTE: reset is synchronous and active-high here, so it lives inside the clocked branch, not the sensitivity list.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign rd_data_o = (rd_sel_i == RD_HI) ? hi_q : lo_q;

endmodule

// File: rtl/hilo_ctrl.sv
// Sequences a mult/div request to an external engine, guards divide-by-zero
// and engine hangs, and owns the HI/LO register file.
module hilo_ctrl
    import hilo_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        MultOrDiv,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        eng_start,
    output logic        eng_MultOrDiv,
    output logic [31:0] eng_A,
    output logic [31:0] eng_B,
    input  logic        eng_done,
    input  logic [31:0] eng_hi,
    input  logic [31:0] eng_lo,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wr_data,
    input  logic        rd_sel,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic        timeout
);

    localparam int             CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              eng_start_q, done_q, div_zero_q, timeout_q, eng_mod_q;
    logic [31:0]       eng_a_q, eng_b_q;

    logic capture;
    logic div_by_zero;

    assign capture     = (state_q == ST_WAIT) && eng_done;
    assign div_by_zero = MultOrDiv && (B == 32'd0);
    assign busy        = (state_q != ST_IDLE);

    // NOTE: all state here is sequential, so every assignment is non-blocking (<=).
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            eng_start_q <= 1'b0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
            timeout_q   <= 1'b0;
            eng_mod_q   <= 1'b0;
            eng_a_q     <= '0;
            eng_b_q     <= '0;
        end else begin
            eng_start_q <= 1'b0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
            timeout_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (div_by_zero) begin
                            div_zero_q <= 1'b1;
                        end else begin
                            eng_a_q     <= A;
                            eng_b_q     <= B;
                            eng_mod_q   <= MultOrDiv;
                            eng_start_q <= 1'b1;
                            state_q     <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    // A result on the terminal-count cycle still counts as success.
                    if (eng_done) begin
                        done_q  <= 1'b1;
                        state_q <= ST_WRITE;
                    end else if (cnt_q == CNT_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_WRITE: state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign eng_start     = eng_start_q;
    assign eng_MultOrDiv = eng_mod_q;
    assign eng_A         = eng_a_q;
    assign eng_B         = eng_b_q;
    assign done          = done_q;
    assign div_zero      = div_zero_q;
    assign timeout       = timeout_q;

    hilo_regs u_regs (
        .clk_i     (clock),
        .rst_i     (reset),
        .cap_i     (capture),
        .cap_hi_i  (eng_hi),
        .cap_lo_i  (eng_lo),
        .wr_en_i   (!busy),
        .wr_hi_i   (wr_hi),
        .wr_lo_i   (wr_lo),
        .wr_data_i (wr_data),
        .rd_sel_i  (rd_sel),
        .rd_data_o (rd_data)
    );

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 40: max cycles WAIT holds for eng_done before abort.
REQ-002 clock  in  1  single clock, all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high; sampled on rising edge of clock.
REQ-004 start  in  1  one-cycle request for a mult/div operation.
REQ-005 MultOrDiv  in  1  operation select: 0 = mult, 1 = div.
REQ-006 A  in  32  signed operand A.
REQ-007 B  in  32  signed operand B (divisor for div).
REQ-008 eng_start  out  1  one-cycle start pulse to the mult/div engine.
REQ-009 eng_MultOrDiv  out  1  latched operation select to engine.
REQ-010 eng_A, eng_B  out  32 each  latched operands to engine, stable from ISSUE until return to IDLE.
REQ-011 eng_done  in  1  engine result-valid pulse.
REQ-012 eng_hi, eng_lo  in  32 each  engine result halves, valid when eng_done=1.
REQ-013 wr_hi, wr_lo  in  1 each  direct write strobes (mthi/mtlo).
REQ-014 wr_data  in  32  data for wr_hi/wr_lo.
REQ-015 rd_sel  in  1  read select: 0 = LO, 1 = HI.
REQ-016 rd_data  out  32  combinational read of selected HI/LO register.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done, div_zero, timeout  out  1 each  one-cycle status pulses.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, WRITE; reset state IDLE.
REQ-020 IDLE + start, div with B==0: div_zero=1 next cycle, state stays IDLE, HI/LO unchanged, no eng_start.
REQ-021 IDLE + start otherwise: latch A, B, MultOrDiv into eng_A/eng_B/eng_MultOrDiv; next state ISSUE.
REQ-022 ISSUE: eng_start=1 for exactly this cycle; cycle counter cleared; next state WAIT.
REQ-023 WAIT: counter increments each cycle; eng_done=1 captures eng_hi->HI, eng_lo->LO on that edge; next state WRITE.
REQ-024 WAIT, counter reaches TIMEOUT-1 without eng_done: timeout=1 one cycle, HI/LO unchanged, next state IDLE.
REQ-025 WRITE: done=1 for exactly this cycle; next state IDLE.
REQ-026 Latency: start sampled at edge N -> eng_start high cycle N+1 -> done high the cycle after eng_done is sampled.
REQ-027 start while busy=1 SHALL be ignored (no queueing).
REQ-028 eng_done outside WAIT SHALL be ignored.
REQ-029 wr_hi/wr_lo SHALL update HI/LO only when busy=0; ignored while busy.
REQ-030 IDLE with start and wr_hi/wr_lo same cycle: write applied and start accepted; later result overwrites.
REQ-031 wr_hi and wr_lo together SHALL write wr_data to both registers.
REQ-032 rd_data SHALL reflect pre-operation HI/LO while busy; new values visible in WRITE.
REQ-033 eng_done and timeout terminal count same cycle: eng_done wins, no timeout pulse.

Reset
REQ-034 reset SHALL force IDLE; clear HI, LO, counter, eng_A, eng_B, eng_MultOrDiv to 0.
REQ-035 Outputs during/after reset: eng_start, busy, done, div_zero, timeout = 0; rd_data = 0.
REQ-036 reset mid-operation SHALL abort immediately; subsequent eng_done ignored until new ISSUE.

Structure
REQ-037 Shared package hilo_pkg: FSM state encoding, TIMEOUT default, RD_LO=0/RD_HI=1 constants.
REQ-038 One sub-module hilo_regs: HI/LO storage, write priority (engine result vs wr_*), read mux.
REQ-039 Engine instance external; hilo_ctrl contains no arithmetic beyond B==0 compare and counter.

Verification
REQ-040 mult A=7, B=-3, engine returns hi=FFFFFFFF lo=FFFFFFEB after 33 cycles -> done pulse, rd_sel=1 reads FFFFFFFF, rd_sel=0 reads FFFFFFEB.
REQ-041 div A=100, B=0 -> div_zero pulse next cycle, no eng_start, HI/LO keep prior values.
REQ-042 start, engine never asserts eng_done -> timeout pulse after 40 WAIT cycles, busy drops, HI/LO unchanged.
REQ-043 wr_hi=1 data=0x12345678 while busy -> ignored; same write in IDLE -> HI=0x12345678.
REQ-044 reset asserted 10 cycles into WAIT, eng_done pulsed 5 cycles later -> HI=LO=0, no done pulse.
REQ-045 second start during WAIT -> ignored, eng_start pulses once, single done.
